// File: rtl/key_unpack_tx_pkg.sv
// Shared DES key definitions: lane/key widths, FSM states, PC1 table and
// its forward and inverse bit maps (inverse map leaves parity bits at zero).
package key_unpack_tx_pkg;

    localparam int BYTE_W  = 8;
    localparam int KEY56_W = 56;
    localparam int KEY64_W = 64;
    localparam int N_BYTES = KEY64_W / BYTE_W;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Output bit i (1 = MSB) of PC1 takes key bit PC1_TBL[i-1] (1 = MSB of K64).
    localparam int PC1_TBL [KEY56_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    function automatic logic [KEY56_W-1:0] pc1_fwd(input logic [KEY64_W-1:0] k64);
        logic [KEY56_W-1:0] r;
        r = '0;
        for (int i = 0; i < KEY56_W; i++)
            r[6'(KEY56_W - 1 - i)] = k64[6'(KEY64_W - PC1_TBL[i])];
        return r;
    endfunction

    function automatic logic [KEY64_W-1:0] pc1_inv_map(input logic [KEY56_W-1:0] key);
        logic [KEY64_W-1:0] k;
        k = '0;
        for (int i = 0; i < KEY56_W; i++)
            k[6'(KEY64_W - PC1_TBL[i])] = key[6'(KEY56_W - 1 - i)];
        return k;
    endfunction

endpackage

// File: rtl/key_unpack_tx_if.sv
// Key-in / byte-out handshake bundle; master is the key source and byte sink,
// slave is the unpacker.
interface key_unpack_tx_if;
    import key_unpack_tx_pkg::*;

    logic [KEY56_W-1:0] in_key;
    logic               in_valid;
    logic               in_ready;
    logic [BYTE_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;

    modport master (
        output in_key, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_key, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/key_unpack_tx_pc1_inv.sv
// Combinational inverse PC1: 56-bit C0||D0 back to a 64-bit DES key with
// every byte forced to odd parity via its bit 0.
module pc1_inv
    import key_unpack_tx_pkg::*;
(
    input  logic [KEY56_W-1:0] key_i,
    output logic [KEY64_W-1:0] k64_o
);

    always_comb begin
        k64_o = pc1_inv_map(key_i);
        for (int b = 0; b < N_BYTES; b++)
            k64_o[6'(b * BYTE_W)] = ~^k64_o[6'(b * BYTE_W + 1) +: 7];
    end

endmodule

// File: rtl/key_unpack_tx.sv
// Unpacks one PC1-ordered key into a byte packet (raw DES bytes or 7-bit chars).
// First byte 1 cycle after key accept; bytes hold under backpressure; next key loads with the last byte.
module key_unpack_tx
    import key_unpack_tx_pkg::*;
#(
    parameter bit OUT_ASCII = 1'b1,
    parameter bit TRIM_NUL  = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    key_unpack_tx_if.slave   bus
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [KEY64_W-1:0] k64_q, k64_d;

    logic [KEY64_W-1:0] k64_w;
    logic [3:0]         trim_len;
    logic [IDX_W-1:0]   load_last;
    logic [BYTE_W-1:0]  cur_byte;
    logic               is_last;
    logic               in_xfer;
    logic               out_xfer;
    logic               load;

    pc1_inv u_pc1_inv (
        .key_i (bus.in_key),
        .k64_o (k64_w)
    );

    // Packet length is the index of the first all-zero char of the new key.
    always_comb begin
        trim_len = 4'd8;
        for (int j = N_BYTES - 1; j >= 0; j--)
            if (k64_w[6'(KEY64_W - 1 - BYTE_W * j) -: 7] == 7'd0)
                trim_len = 4'(j);
    end

    always_comb begin
        if (!OUT_ASCII || !TRIM_NUL || trim_len == 4'd8)
            load_last = 3'd7;
        else if (trim_len == 4'd0)
            load_last = 3'd0;
        else
            load_last = 3'(trim_len - 4'd1);
    end

    assign cur_byte = k64_q[{~idx_q, 3'b111} -: BYTE_W];
    assign is_last  = (idx_q == last_q);
    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            k64_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            k64_q   <= k64_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        k64_d   = k64_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_xfer)
                    load = 1'b1;
            end
            SEND: begin
                if (out_xfer) begin
                    if (!is_last)
                        idx_d = idx_q + 3'd1;
                    else if (in_xfer)
                        load = 1'b1;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = SEND;
            idx_d   = '0;
            last_d  = load_last;
            k64_d   = k64_w;
        end
    end

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        bus.in_ready  = 1'b1;
        if (state_q == SEND) begin
            bus.out_valid = 1'b1;
            bus.out_data  = OUT_ASCII ? {1'b0, cur_byte[BYTE_W-1:1]} : cur_byte;
            bus.out_last  = is_last;
            bus.in_ready  = bus.out_ready && is_last;
        end
    end

endmodule

// File: tb/tb_key_unpack_tx.sv
// Bench for key_unpack_tx: raw, trimmed-ASCII and full-ASCII instances checked
// against a search-based inverse-PC1 model and a forward-PC1 round trip.
module tb_key_unpack_tx;

    logic        clk, rst;
    logic [55:0] in_key;
    logic        in_valid, out_ready, bp_en;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid, out_last, in_ready;
    logic [55:0] key_ab;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0]  exp_q [$];
    logic [55:0] key_q [$];
    bit          rst_prev = 0, first_chk = 0, held = 0, held_last = 0;
    logic [7:0]  held_dat = '0;
    logic [63:0] rx_k64 = '0;
    int          rx_n = 0;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    key_unpack_tx_if b0 ();
    key_unpack_tx_if b1 ();
    key_unpack_tx_if b2 ();

    assign b0.in_key = in_key;
    assign b1.in_key = in_key;
    assign b2.in_key = in_key;
    assign b0.in_valid = in_valid && (sel == 2'd0);
    assign b1.in_valid = in_valid && (sel == 2'd1);
    assign b2.in_valid = in_valid && (sel == 2'd2);
    assign b0.out_ready = out_ready;
    assign b1.out_ready = out_ready;
    assign b2.out_ready = out_ready;

    key_unpack_tx #(.OUT_ASCII(1'b0), .TRIM_NUL(1'b1)) u_raw  (.CLK(clk), .RST(rst), .bus(b0));
    key_unpack_tx #(.OUT_ASCII(1'b1), .TRIM_NUL(1'b1)) u_trim (.CLK(clk), .RST(rst), .bus(b1));
    key_unpack_tx #(.OUT_ASCII(1'b1), .TRIM_NUL(1'b0)) u_full (.CLK(clk), .RST(rst), .bus(b2));

    always_comb begin
        case (sel)
            2'd1: begin
                out_data = b1.out_data; out_valid = b1.out_valid;
                out_last = b1.out_last; in_ready  = b1.in_ready;
            end
            2'd2: begin
                out_data = b2.out_data; out_valid = b2.out_valid;
                out_last = b2.out_last; in_ready  = b2.in_ready;
            end
            default: begin
                out_data = b0.out_data; out_valid = b0.out_valid;
                out_last = b0.out_last; in_ready  = b0.in_ready;
            end
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each non-parity K64 position is found by searching PC1 for it.
    function automatic logic [63:0] ref_k64(input logic [55:0] key);
        logic [63:0] k;
        k = '0;
        for (int p = 1; p <= 64; p++)
            for (int i = 0; i < 56; i++)
                if (PC1[i] == p) k[6'(64 - p)] = key[6'(55 - i)];
        for (int b = 0; b < 8; b++)
            if ($countones(k[6'(8 * b) +: 8]) % 2 == 0) k[6'(8 * b)] = 1'b1;
        return k;
    endfunction

    function automatic logic [55:0] ref_fwd(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
        return r;
    endfunction

    function automatic int ref_len(input logic [63:0] k, input logic [1:0] m);
        logic [7:0] b;
        if (m != 2'd1) return 8;
        for (int j = 0; j < 8; j++) begin
            b = k[6'(63 - 8 * j) -: 8];
            if (b[7:1] == 7'd0) return j;
        end
        return 8;
    endfunction

    task automatic push_packet(input logic [55:0] key, input logic [1:0] m);
        logic [63:0] k;
        logic [7:0]  b;
        int          n;
        k = ref_k64(key);
        n = ref_len(k, m);
        if (n == 0) exp_q.push_back({1'b1, 8'h00});
        for (int j = 0; j < n; j++) begin
            b = k[6'(63 - 8 * j) -: 8];
            exp_q.push_back({(j == n - 1), (m == 2'd0) ? b : {1'b0, b[7:1]}});
        end
        key_q.push_back(key);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        logic [8:0]  e;
        logic [55:0] kk;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete(); key_q.delete();
                rst_prev = 1; first_chk = 0; held = 0; rx_n = 0; rx_k64 = '0;
            end else begin
                if (rst_prev) begin
                    check("reset_out_valid", out_valid, 0);
                    check("reset_out_last", out_last, 0);
                    check("reset_out_data", out_data, 0);
                    check("reset_in_ready", in_ready, 1);
                    rst_prev = 0;
                end
                if (first_chk) check("first_byte_latency", out_valid, 1);
                if (held) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, held_dat);
                    check("hold_last", out_last, held_last);
                end
                check("in_ready_rule", in_ready, out_valid ? (out_ready && out_last) : 1'b1);
                if (out_valid && out_ready) begin
                    check("byte_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e[7:0]);
                        check("out_last", out_last, e[8]);
                    end
                    rx_k64 = {rx_k64[55:0], (sel == 2'd0) ? out_data : {out_data[6:0], 1'b0}};
                    rx_n++;
                    if (out_last) begin
                        if (key_q.size() != 0) begin
                            kk = key_q.pop_front();
                            if (rx_n == 8) check("pc1_roundtrip", ref_fwd(rx_k64), kk);
                        end
                        rx_n = 0;
                    end
                end
                held      = out_valid && !out_ready;
                held_dat  = out_data;
                held_last = out_last;
                first_chk = in_valid && in_ready;
                if (first_chk) push_packet(in_key, sel);
            end
        end
    end

    task automatic send_key(input logic [55:0] k);
        bit ok;
        ok = 0;
        in_key = k;
        in_valid = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_accepted", ok, 1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !out_valid;
        end
        check("drain_done", done, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] r;
        int          j;
        rst = 1'b1; in_valid = 1'b0; in_key = '0; sel = 2'd0; bp_en = 1'b0;
        key_ab = ref_fwd(64'hC2C4_0000_0000_0000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("model_des_vector", ref_k64(56'hF0CCAAF556678F), 64'h133457799BBCDFF1);
        check("fwd_des_vector", ref_fwd(64'h133457799BBCDFF1), 56'hF0CCAAF556678F);
        check("model_all_ones", ref_k64({56{1'b1}}), 64'hFEFEFEFEFEFEFEFE);
        check("model_zero", ref_k64(56'h0), 64'h0101010101010101);
        check("model_ab", ref_k64(key_ab), 64'hC2C4010101010101);
        check("len_ab", ref_len(ref_k64(key_ab), 2'd1), 2);
        check("len_zero", ref_len(ref_k64(56'h0), 2'd1), 0);

        // Raw DES bytes.
        send_key({56{1'b1}});
        @(negedge clk);
        check("raw_ones_byte0", out_data, 8'hFE);
        drain();
        send_key(56'h0);
        @(negedge clk);
        check("raw_zero_byte0", out_data, 8'h01);
        drain();
        send_key(56'hF0CCAAF556678F);
        drain();
        send_key({56{1'b1}});
        send_key({56{1'b1}});
        drain();

        bp_en = 1'b1;
        repeat (1000) begin
            r = {$urandom(), $urandom()};
            send_key(56'(r));
        end
        bp_en = 1'b0;
        drain();

        // Reset while byte index 2 is on the bus.
        send_key({56{1'b1}});
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send_key(56'h0);
        @(negedge clk);
        check("after_reset_byte0", out_data, 8'h01);
        drain();

        // Trimmed ASCII.
        sel = 2'd1;
        send_key(56'h0);
        @(negedge clk);
        check("trim_zero_data", out_data, 8'h00);
        check("trim_zero_last", out_last, 1);
        drain();
        send_key(key_ab);
        @(negedge clk);
        check("ab_char0", out_data, 8'h61);
        @(negedge clk);
        check("ab_char1", out_data, 8'h62);
        check("ab_last", out_last, 1);
        drain();
        send_key({56{1'b1}});
        send_key(ref_fwd(64'h4142434400464748));
        bp_en = 1'b1;
        repeat (300) begin
            r = {$urandom(), $urandom()};
            j = $urandom_range(0, 8);
            if (j < 8) r[6'(63 - 8 * j) -: 8] = 8'h00;
            send_key(ref_fwd(r));
        end
        bp_en = 1'b0;
        drain();

        // Untrimmed ASCII.
        sel = 2'd2;
        send_key(56'h0);
        drain();
        send_key(key_ab);
        bp_en = 1'b1;
        repeat (100) begin
            r = {$urandom(), $urandom()};
            j = $urandom_range(0, 8);
            if (j < 8) r[6'(63 - 8 * j) -: 8] = 8'h00;
            send_key(ref_fwd(r));
        end
        bp_en = 1'b0;
        drain();

        check("queue_empty_at_end", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_unpack_tx.md
KEY_UNPACK_TX -- requirements
Module: key_unpack_tx

Interface
REQ-001 Parameter OUT_ASCII, default 1: 1 = emit 7-bit password chars; 0 = emit raw 64-bit DES key bytes with parity.
REQ-002 Parameter TRIM_NUL, default 1: when OUT_ASCII=1, end the packet before the first 0x00 char; ignored when OUT_ASCII=0.
REQ-003 CLK  input  1  sole clock; all logic on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 in_key  input  56  C0||D0 key in forward-PC1 output bit order (bit 55 first).
REQ-006 in_valid  input  1  in_key is valid.
REQ-007 in_ready  output  1  block accepts in_key this cycle.
REQ-008 out_data  output  8  output byte.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  sink accepts out_data this cycle.
REQ-011 out_last  output  1  marks the final byte of a packet.

Function
REQ-012 Input and output transfers SHALL each occur on a cycle with valid&&ready high.
REQ-013 On input transfer, the block SHALL register K64, the 64-bit inverse of forward PC1: PC1(K64) == in_key on all 56 key bits.
REQ-014 Parity bits K64[0], K64[8], ..., K64[56] SHALL be set so that each byte K64[8k+7:8k] has odd parity.
REQ-015 Byte k (k = 0..7) SHALL be K64[63-8k -: 8]; bytes SHALL be emitted in order k = 0 first.
REQ-016 When OUT_ASCII=0, out_data SHALL be byte k including parity, and each packet SHALL contain exactly 8 bytes.
REQ-017 When OUT_ASCII=1, out_data SHALL be {1'b0, byte k[7:1]}.
REQ-018 With OUT_ASCII=1 and TRIM_NUL=1, packet length SHALL be L = index of the first zero char (8 if none).
REQ-019 With OUT_ASCII=1 and TRIM_NUL=1, L = 0 SHALL emit a single byte 0x00 with out_last=1.
REQ-020 With OUT_ASCII=1 and TRIM_NUL=0, each packet SHALL contain exactly 8 bytes.
REQ-021 L SHALL be computed in the load cycle and stored with K64.
REQ-022 The FSM SHALL have states IDLE and SEND plus a 3-bit byte counter idx.
REQ-023 IDLE: in_ready=1 and out_valid=0; an input transfer SHALL load K64 and L, clear idx, and enter SEND.
REQ-024 SEND: out_valid=1 and out_data=byte idx; out_last SHALL be 1 when idx equals the last byte index.
REQ-025 SEND: out_data, out_last and idx SHALL hold stable while out_valid&&!out_ready.
REQ-026 SEND: on a non-last output transfer, idx SHALL increment by 1.
REQ-027 SEND: in_ready SHALL equal out_ready&&out_last, so the next key loads in the same cycle the last byte transfers.
REQ-028 On the last-byte transfer: if a simultaneous input transfer occurs, the block SHALL reload and stay in SEND with idx=0; otherwise it SHALL return to IDLE.
REQ-029 First-byte latency SHALL be 1 cycle after the input transfer; a sink with out_ready held high SHALL see zero bubbles between back-to-back packets.
REQ-030 idx SHALL never wrap past 7; no byte SHALL be dropped or duplicated under any out_ready pattern.

Reset
REQ-031 RST SHALL force IDLE, idx=0, out_valid=0, out_last=0 and out_data=8'h00; in_ready SHALL be 1 in the first cycle after reset.
REQ-032 RST asserted mid-packet SHALL abandon the packet; no further bytes of it SHALL appear.
REQ-033 in_valid SHALL be ignored while RST is high.

Structure
REQ-034 The inverse-PC1 bit map SHALL live in the shared DES package as a function, next to the forward PC1 table.
REQ-035 The byte-lane width (8) and key widths (56, 64) SHALL be package constants.
REQ-036 Inverse-PC1 plus parity generation SHALL be one combinational sub-module, pc1_inv; the FSM SHALL be the top level.

Verification
REQ-037 OUT_ASCII=0, in_key=56'hFF_FFFF_FFFF_FFFF, out_ready=1 -> 8 bytes 0xFE, out_last on byte 8, first byte 1 cycle after the input transfer.
REQ-038 OUT_ASCII=0, in_key=0 -> 8 bytes 0x01; OUT_ASCII=1, TRIM_NUL=1, in_key=0 -> single 0x00 with out_last=1.
REQ-039 OUT_ASCII=1, TRIM_NUL=1, in_key=PC1({8'hC2,8'hC4,48'h0}) ("ab") -> 0x61 then 0x62 with out_last.
REQ-040 Two back-to-back all-ones keys, out_ready=1 -> 16 contiguous bytes; in_ready pulses on byte 8 only.
REQ-041 Random out_ready backpressure on 1000 random keys -> each packet matches a reference model of inverse PC1, parity and trim; the PC1 round-trip matches in_key.
REQ-042 RST asserted on byte 3 of a packet -> out_valid=0 the next cycle; the next key starts at byte 0.
